// File: rtl/conv_window_feeder_pkg.sv
// Shared defaults and sizing helpers for the convolution window feeder.
// The defaults mirror the PE multiply-adder operand geometry.
package conv_window_feeder_pkg;
  localparam int CONV_MULT_WIDTH     = 8;
  localparam int MA_TREE_SIZE        = 3;
  localparam int MULT_ADDER_IN_WIDTH = CONV_MULT_WIDTH * MA_TREE_SIZE;

  // Counter width for a count range of n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_window_shift.sv
// TREE_SIZE-deep pixel shift register; new pixels enter the top element,
// element 0 (low bits) holds the oldest pixel.
module conv_window_shift
  import conv_window_feeder_pkg::*;
#(
  parameter int MULT_WIDTH = CONV_MULT_WIDTH,
  parameter int TREE_SIZE  = MA_TREE_SIZE
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            shift_en_i,
  input  logic [MULT_WIDTH-1:0]           din_i,
  output logic [TREE_SIZE*MULT_WIDTH-1:0] win_o
);
  logic [TREE_SIZE*MULT_WIDTH-1:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (shift_en_i) win_d = {din_i, win_q[TREE_SIZE*MULT_WIDTH-1:MULT_WIDTH]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) win_q <= '0;
    else       win_q <= win_d;
  end

  assign win_o = win_q;
endmodule

// File: rtl/conv_window_feeder.sv
// Loads a kernel serially, then slides a per-row window over a pixel stream
// and presents window/kernel operand pairs to the PE with valid/ready.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int MULT_WIDTH = CONV_MULT_WIDTH,
  parameter int TREE_SIZE  = MA_TREE_SIZE,
  parameter int ROW_LEN    = 32,
  parameter int NUM_ROWS   = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [MULT_WIDTH-1:0]           k_data,
  input  logic                            k_valid,
  output logic                            k_ready,
  input  logic [MULT_WIDTH-1:0]           pix_data,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  output logic [TREE_SIZE*MULT_WIDTH-1:0] out_in,
  output logic [TREE_SIZE*MULT_WIDTH-1:0] out_kernel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            done
);
  localparam int VW    = TREE_SIZE * MULT_WIDTH;
  localparam int COL_W = cnt_w(ROW_LEN);
  localparam int ROW_W = cnt_w(NUM_ROWS);
  localparam int KC_W  = $clog2(TREE_SIZE + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_K = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [KC_W-1:0]  k_cnt_q, k_cnt_d;
  logic [KC_W-1:0]  fill_q, fill_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [VW-1:0]    kernel_q, kernel_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic [VW-1:0]    win;
  logic             pix_acc;

  assign k_ready   = (state_q == S_LOAD_K);
  assign pix_ready = (state_q == S_STREAM) && (!out_valid_q || out_ready);
  assign pix_acc   = pix_valid && pix_ready;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  // The window only moves on a pixel accept, which backpressure blocks,
  // so it is already stable while an output is pending.
  assign out_in     = {VW{out_valid_q}} & win;
  assign out_kernel = {VW{out_valid_q}} & kernel_q;

  conv_window_shift #(
    .MULT_WIDTH(MULT_WIDTH),
    .TREE_SIZE (TREE_SIZE)
  ) u_shift (
    .clock     (clock),
    .reset     (reset),
    .shift_en_i(pix_acc),
    .din_i     (pix_data),
    .win_o     (win)
  );

  always_comb begin
    state_d     = state_q;
    k_cnt_d     = k_cnt_q;
    fill_d      = fill_q;
    col_d       = col_q;
    row_d       = row_q;
    kernel_d    = kernel_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_K;
          k_cnt_d = '0;
        end
      end
      S_LOAD_K: begin
        if (k_valid) begin
          for (int i = 0; i < TREE_SIZE; i++)
            if (k_cnt_q == KC_W'(i)) kernel_d[i*MULT_WIDTH +: MULT_WIDTH] = k_data;
          k_cnt_d = k_cnt_q + 1'b1;
          if (k_cnt_q == KC_W'(TREE_SIZE - 1)) begin
            state_d = S_STREAM;
            col_d   = '0;
            row_d   = '0;
            fill_d  = '0;
          end
        end
      end
      S_STREAM: begin
        if (pix_acc) begin
          if (fill_q == KC_W'(TREE_SIZE - 1)) out_valid_d = 1'b1;
          else                                fill_d      = fill_q + 1'b1;
          // A window never straddles rows: restart filling on the new row.
          if (col_q == COL_W'(ROW_LEN - 1)) begin
            col_d  = '0;
            fill_d = '0;
            row_d  = row_q + 1'b1;
            if (row_q == ROW_W'(NUM_ROWS - 1)) begin
              state_d = S_DRAIN;
              row_d   = '0;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_cnt_q     <= '0;
      fill_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      kernel_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_cnt_q     <= k_cnt_d;
      fill_q      <= fill_d;
      col_q       <= col_d;
      row_q       <= row_d;
      kernel_q    <= kernel_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder with a 5-pixel x 2-row frame.
module tb_conv_window_feeder;
  localparam int MW = 8;
  localparam int TS = 3;
  localparam int RL = 5;
  localparam int NR = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [MW-1:0]     k_data;
  logic              k_valid;
  logic              k_ready;
  logic [MW-1:0]     pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [TS*MW-1:0]  out_in;
  logic [TS*MW-1:0]  out_kernel;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  conv_window_feeder #(
    .MULT_WIDTH(MW), .TREE_SIZE(TS), .ROW_LEN(RL), .NUM_ROWS(NR)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .k_data(k_data), .k_valid(k_valid), .k_ready(k_ready),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .out_in(out_in), .out_kernel(out_kernel), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_kernel(input logic [MW-1:0] w0, input logic [MW-1:0] w1,
                             input logic [MW-1:0] w2);
    start = 1'b1; tick(); start = 1'b0;
    chk("load_k_ready", 32'(k_ready), 32'd1);
    k_valid = 1'b1;
    k_data = w0; tick();
    k_data = w1; tick();
    k_data = w2; tick();
    k_valid = 1'b0;
    chk("load_k_ready_drop", 32'(k_ready), 32'd0);
  endtask

  // Accept one pixel (pix_valid left high so pixels can stream back to back).
  task automatic push(input logic [MW-1:0] p);
    pix_data = p; pix_valid = 1'b1; tick();
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] win);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, "_in"}, 32'(out_in), win);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; k_data = '0; k_valid = 1'b0;
    pix_data = '0; pix_valid = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_in", 32'(out_in), 32'd0);
    chk("rst_out_kernel", 32'(out_kernel), 32'd0);
    chk("rst_k_ready", 32'(k_ready), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_pix_ready", 32'(pix_ready), 32'd0);

    // Frame 1: kernel 1,2,3 and free-flowing output.
    load_kernel(8'd1, 8'd2, 8'd3);
    chk("stream_pix_ready", 32'(pix_ready), 32'd1);
    chk("stream_busy", 32'(busy), 32'd1);

    // start and k_valid in STREAM must not disturb anything.
    start = 1'b1; k_valid = 1'b1; k_data = 8'hFF; tick();
    start = 1'b0; k_valid = 1'b0;
    chk("ign_k_ready", 32'(k_ready), 32'd0);
    chk("ign_pix_ready", 32'(pix_ready), 32'd1);
    chk("ign_out_valid", 32'(out_valid), 32'd0);

    push(8'd10); chk_out("r0_p10", 1'b0, 32'h0);
    push(8'd11); chk_out("r0_p11", 1'b0, 32'h0);
    push(8'd12); chk_out("r0_w0", 1'b1, 32'h0C0B0A);
    chk("r0_kernel", 32'(out_kernel), 32'h030201);
    push(8'd13); chk_out("r0_w1", 1'b1, 32'h0D0C0B);
    push(8'd14); chk_out("r0_w2", 1'b1, 32'h0E0D0C);
    push(8'd20); chk_out("r1_p20", 1'b0, 32'h0);
    push(8'd21); chk_out("r1_p21", 1'b0, 32'h0);
    push(8'd22); chk_out("r1_w0", 1'b1, 32'h161514);
    push(8'd23); chk_out("r1_w1", 1'b1, 32'h171615);
    push(8'd24); chk_out("r1_w2", 1'b1, 32'h181716);
    pix_valid = 1'b0;
    chk("drain_pix_ready", 32'(pix_ready), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    tick();
    chk("f1_done", 32'(done), 32'd1);
    chk("f1_busy", 32'(busy), 32'd0);
    chk("f1_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("f1_done_pulse", 32'(done), 32'd0);

    // Frame 2: new kernel, backpressure on the first window and in DRAIN.
    load_kernel(8'd4, 8'd5, 8'd6);
    out_ready = 1'b0;
    push(8'd10); push(8'd11); push(8'd12);
    chk_out("bp_w0", 1'b1, 32'h0C0B0A);
    chk("bp_kernel", 32'(out_kernel), 32'h060504);
    pix_data = 8'd13;
    for (int i = 0; i < 3; i++) begin
      chk("bp_pix_ready", 32'(pix_ready), 32'd0);
      tick();
      chk_out("bp_hold", 1'b1, 32'h0C0B0A);
    end
    out_ready = 1'b1;
    tick(); chk_out("bp_w1", 1'b1, 32'h0D0C0B);
    push(8'd14); chk_out("bp_w2", 1'b1, 32'h0E0D0C);
    push(8'd20); push(8'd21);
    push(8'd22); chk_out("bp_r1_w0", 1'b1, 32'h161514);
    push(8'd23); chk_out("bp_r1_w1", 1'b1, 32'h171615);
    push(8'd24); chk_out("bp_r1_w2", 1'b1, 32'h181716);
    pix_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk_out("bp_drain_hold", 1'b1, 32'h181716);
    chk("bp_drain_done", 32'(done), 32'd0);
    chk("bp_drain_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("f2_done", 32'(done), 32'd1);
    chk("f2_busy", 32'(busy), 32'd0);
    chk("f2_out_valid", 32'(out_valid), 32'd0);

    // Frame 3: asynchronous reset while a window is being presented.
    load_kernel(8'd7, 8'd8, 8'd9);
    push(8'd10); push(8'd11); push(8'd12);
    pix_valid = 1'b0;
    chk_out("mid_w0", 1'b1, 32'h0C0B0A);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in", 32'(out_in), 32'd0);
    chk("mid_rst_kernel", 32'(out_kernel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pix_ready", 32'(pix_ready), 32'd0);
    #2;
    reset = 1'b0;
    pix_data = 8'h33; pix_valid = 1'b1;
    tick(); tick();
    chk("post_rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    pix_valid = 1'b0;
    load_kernel(8'd1, 8'd2, 8'd3);
    push(8'd40); chk_out("re_p40", 1'b0, 32'h0);
    push(8'd41); chk_out("re_p41", 1'b0, 32'h0);
    push(8'd42); chk_out("re_w0", 1'b1, 32'h2A2928);
    chk("re_kernel", 32'(out_kernel), 32'h030201);
    pix_valid = 1'b0;
    tick();
    chk("re_valid_drop", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Producer side of the PE multiply-add datapath. It generates the packed `in` / `kernel` operand vectors that the PE multiply-adder consumes.
- Loads TREE_SIZE kernel weights serially, then accepts a row-major pixel stream. Keeps a TREE_SIZE-wide sliding window per row.
- Emits one packed window plus the kernel vector per valid output position, with a valid/ready handshake toward the PE.
- Windows never span a row boundary.

Parameters:
- MULT_WIDTH, 8, bits per pixel/weight element (matches `CONV_MULT_WIDTH).
- TREE_SIZE, 3, elements per window (matches `MA_TREE_SIZE).
- ROW_LEN, 32, pixels per row; must be >= TREE_SIZE.
- NUM_ROWS, 32, rows per frame.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins kernel load; honoured only in IDLE.
- k_data  in  MULT_WIDTH  kernel weight.
- k_valid  in  1  weight present.
- k_ready  out  1  high only in LOAD_K.
- pix_data  in  MULT_WIDTH  pixel.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  pixel accepted when pix_valid&&pix_ready.
- out_in  out  TREE_SIZE*MULT_WIDTH  packed window; element 0 (bits MULT_WIDTH-1:0) = oldest pixel.
- out_kernel  out  TREE_SIZE*MULT_WIDTH  packed kernel; element i pairs with window element i.
- out_valid  out  1  output vector valid.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when frame completes.

Behaviour:
- Reset (async assert): state=IDLE. All outputs 0, kernel regs 0, window 0, all counters 0. Same result when reset is asserted mid-operation; no partial output survives.
- States: IDLE, LOAD_K, STREAM, DRAIN.
- IDLE:
  - k_ready=0, pix_ready=0.
  - start -> LOAD_K, k_cnt=0.
- LOAD_K:
  - k_ready=1.
  - Each accepted weight is written to kernel slot k_cnt; the first weight goes to element 0.
  - After the TREE_SIZE-th accept -> STREAM, with col=0, row=0, fill=0.
  - start is ignored.
- STREAM:
  - pix_ready = !out_valid || out_ready. This gives full throughput: an output handshake and a pixel accept may occur in the same cycle.
  - On accept:
    - Window shifts toward element 0; the new pixel enters element TREE_SIZE-1.
    - col increments.
    - fill saturates at TREE_SIZE-1.
  - Output generation:
    - If fill==TREE_SIZE-1 before the accept, the next cycle has out_valid=1, with out_in = the shifted window and out_kernel = the kernel regs.
    - Latency is 1 cycle from the accepting edge.
  - Output hold: if an output handshake occurs with no new window, out_valid goes 0 next cycle. While out_valid && !out_ready, out_in and out_kernel hold stable.
  - Row boundary (accept with col==ROW_LEN-1):
    - col wraps to 0, fill clears to 0, row increments.
    - The window contents may remain, but no output is produced until TREE_SIZE new pixels of the new row are accepted.
  - Windows per row = ROW_LEN-TREE_SIZE+1.
  - Frame end: accept with col==ROW_LEN-1 and row==NUM_ROWS-1 -> DRAIN.
- DRAIN:
  - pix_ready=0.
  - When out_valid==0, or the handshake occurs this cycle -> IDLE, with done=1 for exactly one cycle on entry to IDLE.
- General rules:
  - k_valid is ignored outside LOAD_K; pix_valid is ignored outside STREAM.
  - Kernel regs are unchanged from the end of LOAD_K until the next start.
- Widths: all data is pass-through; no arithmetic on data. Counters are sized $clog2(ROW_LEN), $clog2(NUM_ROWS) and $clog2(TREE_SIZE+1).

Decomposition:
- Shared header bit_width.vh: `CONV_MULT_WIDTH, `MA_TREE_SIZE and `MULT_ADDER_IN_WIDTH (=TREE_SIZE*MULT_WIDTH) supply the parameter defaults. State encodings are local to the module.
- One natural sub-module: conv_window_shift. It is the TREE_SIZE-deep MULT_WIDTH shift register with shift-enable, async reset and a packed parallel output.
- FSM, counters and the output register stay in the top.

Test Plan (TREE_SIZE=3, MULT_WIDTH=8, ROW_LEN=5, NUM_ROWS=2):
1. Kernel load: start, then weights 1,2,3 -> k_ready drops after the third accept; the first out_kernel seen = 24'h030201.
2. Row 0: pixels 10..14 with out_ready=1 -> exactly 3 outputs, out_in = 24'h0C0B0A, 24'h0D0C0B, 24'h0E0D0C. Each appears 1 cycle after the accept of 12/13/14.
3. Row boundary: row 1 pixels 20..24 -> outputs 24'h161514, 24'h171615, 24'h181716 only. No vector containing 13/14 with 20 appears. Then done pulses once and busy=0.
4. Backpressure: hold out_ready=0 after the first window -> out_in stays 24'h0C0B0A, pix_ready=0, and no pixel is lost. Release -> the remaining windows arrive in order.
5. Reset mid-stream: assert reset after pixel 12 -> all outputs 0 and state IDLE immediately. pix_valid is ignored until a new start and kernel load.
6. Ignored inputs: start during STREAM and k_valid during STREAM -> no effect on kernel or outputs.
